iram_load_controller: RTL and testbench
=======================================

# iram_load_controller

Owns the 64-word instruction RAM and sequences its use between a program loader and the processor fetch port. After reset it holds the CPU and accepts a stream of instruction words over a valid/ready handshake, writing them to consecutive addresses from 0. It then releases the CPU, which fetches through a registered read port. A new load session may preempt execution at any time.

## Interface

- DATA_WIDTH, 32, instruction word width
- DEPTH, 64, RAM words; must be a power of two, at most 2^ADDR_WIDTH
- ADDR_WIDTH, 10, fetch address width

Ports:

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load_start  in  1  single-cycle pulse; begins (or restarts) a load session
- load_valid  in  1  loader word present
- load_ready  out  1  controller accepts a word
- load_data  in  DATA_WIDTH  instruction word
- load_last  in  1  qualifies the final word of the session
- load_count  out  $clog2(DEPTH)+1  words written in the current session (0..DEPTH)
- load_error  out  1  sticky overflow flag
- cpu_hold  out  1  CPU must stall (high when not RUN)
- running  out  1  high in RUN
- fetch_req  in  1  fetch strobe
- fetch_address  in  ADDR_WIDTH  word address
- fetch_data  out  DATA_WIDTH  fetched word
- fetch_valid  out  1  fetch_data valid this cycle
- fetch_fault  out  1  one-cycle pulse when a fetch address is >= DEPTH

## Operation

- The RAM is internal: DEPTH x DATA_WIDTH. Reset does not clear it. Words beyond load_count keep their prior contents.
- States are IDLE, LOAD and RUN.
  - IDLE: reset state. load_ready=0, cpu_hold=1. On load_start, go to LOAD.
  - LOAD: load_ready=1. A beat is accepted when load_valid && load_ready at a clock edge. The beat writes RAM[load_count] = load_data, and load_count increments.
    - Accepted beat with load_last: go to RUN.
    - Accepted beat without load_last that makes load_count == DEPTH: set load_error and go to IDLE.
    - load_start in LOAD: load_count=0 and the session restarts. Any beat offered in that same cycle is not written.
  - RUN: cpu_hold=0, running=1, load_ready=0. On load_start, go to LOAD with load_count=0. A fetch_req in that same cycle is ignored.
- load_start clears load_error and load_count on entry to LOAD. In RUN, load_count holds the final session length.
- Fetches are honoured only in RUN. In IDLE and LOAD, fetch_req is ignored and fetch_valid stays 0.
- Fetch with fetch_address < DEPTH: fetch_data = RAM[fetch_address[log2(DEPTH)-1:0]], fetch_valid=1.
- Fetch with fetch_address >= DEPTH: fetch_data=0, fetch_valid=1, fetch_fault=1.
- Writes (LOAD only) and reads (RUN only) never overlap. No bypass is required.

## Timing

- Reset (asynchronous, active-low) forces state=IDLE and drives the following outputs:
  - load_ready=0, cpu_hold=1, running=0
  - fetch_valid=0, fetch_data=0, fetch_fault=0
  - load_count=0, load_error=0
- Reset asserted mid-load aborts the session. Words already written remain.
- load_start sampled at edge N: state=LOAD from N+1, so load_ready=1 during cycle N+1.
- Last beat accepted at edge N: during cycle N+1, running=1 and cpu_hold=0. The word is readable by a fetch issued in cycle N+1.
- Fetch latency is 1 cycle. A fetch_req sampled at edge N gives fetch_data, fetch_valid and fetch_fault during cycle N+1. fetch_valid and fetch_fault are single-cycle unless fetch_req is held.
- Back-to-back fetches sustain one word per cycle.
- load_start in RUN at edge N: cpu_hold=1 from N+1, and fetch_valid=0 in cycle N+1.
- Overflow at edge N: load_error=1 and state IDLE from N+1. cpu_hold stays 1.
- All outputs are registered except load_ready, cpu_hold and running, which decode the state register directly.

## Test plan

- Reset, load_start, then 6 words 0x11..0x16 with load_last on the 6th. Required: load_count=6, running=1 the cycle after the last beat. Fetch addresses 0 and 5 return 0x11 and 0x16, each one cycle after fetch_req.
- Load with load_valid gaps (valid on alternate cycles) and fetch_req held during LOAD. Required: only valid beats are written, load_count tracks beats, fetch_valid stays 0 until RUN.
- 64 beats: first with load_last on beat 64, then a session without it. Required: RUN in the first case. In the second, load_error=1, state IDLE, cpu_hold=1. A later load_start clears load_error.
- In RUN, fetch addresses 63 and 64 back-to-back. Required: RAM[63] with fetch_fault=0, then 0 with fetch_valid=1 and fetch_fault=1.
- In RUN, load_start and fetch_req in the same cycle, then reload 3 words 0xA0..0xA2. Required: no fetch_valid, cpu_hold=1 the next cycle. After RUN, address 3 still holds the old word.
- Assert reset after 4 of 8 beats. Required: all outputs at reset values immediately. A new 8-word load completes normally.

Source files
------------

// File: rtl/iram_load_controller_if.sv
// Loader and fetch signal bundle for the instruction RAM controller.
// The master side is the loader/CPU; the slave side is the controller.
interface iram_load_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 10
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  load_start;
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic [CW-1:0]         load_count;
  logic                  load_error;
  logic                  cpu_hold;
  logic                  running;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_valid;
  logic                  fetch_fault;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, fetch_address,
    input  load_ready, load_count, load_error, cpu_hold, running,
           fetch_data, fetch_valid, fetch_fault
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, fetch_address,
    output load_ready, load_count, load_error, cpu_hold, running,
           fetch_data, fetch_valid, fetch_fault
  );
endinterface

// File: rtl/iram_load_controller.sv
// Instruction RAM owner: loads words over valid/ready from address 0, then
// releases the CPU to fetch through a one-cycle registered read port.
module iram_load_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  iram_load_controller_if.slave bus
);
  localparam int RAW = $clog2(DEPTH);
  localparam int CW  = RAW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]         r_count;
  logic                  r_error;
  logic                  r_fetch_valid;
  logic                  r_fetch_fault;
  logic [DATA_WIDTH-1:0] r_fetch_data;
  logic                  w_beat;
  logic                  w_full;
  logic                  w_fetch;
  logic                  w_in_range;

  // Upper address bits above the RAM index must be zero for an in-range fetch.
  generate
    if (ADDR_WIDTH > RAW) begin : g_range
      assign w_in_range = ~|bus.fetch_address[ADDR_WIDTH-1:RAW];
    end else begin : g_norange
      assign w_in_range = 1'b1;
    end
  endgenerate

  // load_start takes priority: a beat or fetch in the same cycle is dropped.
  assign w_beat  = (r_state == S_LOAD) && bus.load_valid && !bus.load_start;
  assign w_full  = (r_count == CW'(DEPTH - 1));
  assign w_fetch = (r_state == S_RUN) && bus.fetch_req && !bus.load_start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.load_start) w_next = S_LOAD;
      S_LOAD: begin
        if (bus.load_start)     w_next = S_LOAD;
        else if (w_beat) begin
          if (bus.load_last)    w_next = S_RUN;
          else if (w_full)      w_next = S_IDLE;
        end
      end
      S_RUN:  if (bus.load_start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (bus.load_start) begin
        r_count <= '0;
        r_error <= 1'b0;
      end else if (w_beat) begin
        r_count <= r_count + 1'b1;
        if (!bus.load_last && w_full) r_error <= 1'b1;
      end
    end
  end

  // RAM contents survive reset; words past the session length keep old data.
  always_ff @(posedge clock) begin
    if (w_beat) r_mem[r_count[RAW-1:0]] <= bus.load_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fetch_data  <= '0;
    end else begin
      r_fetch_valid <= w_fetch;
      r_fetch_fault <= w_fetch && !w_in_range;
      r_fetch_data  <= (w_fetch && w_in_range) ? r_mem[bus.fetch_address[RAW-1:0]] : '0;
    end
  end

  assign bus.load_ready  = (r_state == S_LOAD);
  assign bus.cpu_hold    = (r_state != S_RUN);
  assign bus.running     = (r_state == S_RUN);
  assign bus.load_count  = r_count;
  assign bus.load_error  = r_error;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.fetch_fault = r_fetch_fault;
  assign bus.fetch_data  = r_fetch_data;
endmodule

// File: tb/tb_iram_load_controller.sv
// Randomized bench for iram_load_controller: a transaction-level model predicts
// status outputs each cycle and queues expected fetch responses for a monitor.
module tb_iram_load_controller;
  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int AW = 10;
  localparam int MI = 0, ML = 1, MR = 2;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        fault;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t          sb[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] model_mem [DEPTH];
  bit            written [DEPTH];
  int            m_mode = MI;
  int            m_count = 0;
  bit            m_err = 1'b0;

  iram_load_controller_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();

  iram_load_controller #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Fetch response monitor: a response is due exactly one cycle after a
  // fetch the model accepted; in every other cycle fetch_valid must be low.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("fetch_valid", 64'(bus.fetch_valid), 64'(1));
        chk("fetch_data", 64'(bus.fetch_data), 64'(e.data));
        chk("fetch_fault", 64'(bus.fetch_fault), 64'(e.fault));
      end else begin
        chk("fetch_valid_idle", 64'(bus.fetch_valid), 64'(0));
        chk("fetch_fault_idle", 64'(bus.fetch_fault), 64'(0));
      end
    end
  end

  task automatic check_status();
    chk("load_ready", 64'(bus.load_ready), 64'(m_mode == ML));
    chk("cpu_hold", 64'(bus.cpu_hold), 64'(m_mode != MR));
    chk("running", 64'(bus.running), 64'(m_mode == MR));
    chk("load_count", 64'(bus.load_count), 64'(m_count));
    chk("load_error", 64'(bus.load_error), 64'(m_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_load_ready"}, 64'(bus.load_ready), 64'(0));
    chk({tag, "_cpu_hold"}, 64'(bus.cpu_hold), 64'(1));
    chk({tag, "_running"}, 64'(bus.running), 64'(0));
    chk({tag, "_fetch_valid"}, 64'(bus.fetch_valid), 64'(0));
    chk({tag, "_fetch_data"}, 64'(bus.fetch_data), 64'(0));
    chk({tag, "_fetch_fault"}, 64'(bus.fetch_fault), 64'(0));
    chk({tag, "_load_count"}, 64'(bus.load_count), 64'(0));
    chk({tag, "_load_error"}, 64'(bus.load_error), 64'(0));
  endtask

  // One clock cycle: drive inputs, apply the behavioural rules to the model,
  // advance past the edge, then compare status outputs.
  task automatic cycle(input bit ls, input bit lv, input logic [DW-1:0] ld,
                       input bit ll, input bit fr, input logic [AW-1:0] fa);
    exp_t e;
    bus.load_start    = ls;
    bus.load_valid    = lv;
    bus.load_data     = ld;
    bus.load_last     = ll;
    bus.fetch_req     = fr;
    bus.fetch_address = fa;
    if (fr && m_mode == MR && !ls) begin
      e.due   = cyc + 1;
      e.fault = (int'(fa) >= DEPTH);
      e.data  = e.fault ? '0 : model_mem[int'(fa)];
      sb.push_back(e);
    end
    if (ls) begin
      m_mode = ML; m_count = 0; m_err = 1'b0;
    end else if (m_mode == ML && lv) begin
      model_mem[m_count] = ld;
      written[m_count] = 1'b1;
      m_count++;
      if (ll) m_mode = MR;
      else if (m_count == DEPTH) begin m_err = 1'b1; m_mode = MI; end
    end
    @(posedge clock); #1;
    check_status();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int a;
    a = $urandom_range(0, 71);
    if ($urandom_range(0, 7) == 0) a = $urandom_range(64, 1023);
    if (a < DEPTH && !written[a]) a = 0;
    return AW'(a);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, DW'($urandom), 0, 0, '0);
  endtask

  task automatic start(input bit fr, input logic [AW-1:0] fa);
    cycle(1, 0, '0, 0, fr, fa);
  endtask

  // Offer every word in wq; optional idle gaps and held fetch_req during LOAD.
  task automatic beats(input bit with_last, input bit gaps, input bit hold_fetch);
    for (int i = 0; i < wq.size(); i++) begin
      if (gaps && i > 0) cycle(0, 0, DW'($urandom), 0, hold_fetch, pick_addr());
      cycle(0, 1, wq[i], with_last && (i == wq.size() - 1), hold_fetch, pick_addr());
    end
  endtask

  task automatic fill_random(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(DW'($urandom));
  endtask

  task automatic fetches(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, 0, '0, 0, ($urandom_range(0, 3) != 0), pick_addr());
  endtask

  initial begin
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0;
    bus.fetch_req = 0; bus.fetch_address = '0;
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;

    #1 check_reset_outputs("por");
    #11 reset = 1'b1;
    idle(2);

    // Directed 6-word load, then fetch addresses 0 and 5
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back(DW'(32'h11 + i));
    start(0, '0);
    beats(1, 0, 0);
    cycle(0, 0, '0, 0, 1, AW'(0));
    cycle(0, 0, '0, 0, 1, AW'(5));
    idle(1);
    fetches(10);

    // Gapped load with fetch_req held throughout
    fill_random(10);
    start(0, '0);
    beats(1, 1, 1);
    fetches(20);

    // Full 64-word load with load_last, boundary fetches 63 then 64
    fill_random(DEPTH);
    start(0, '0);
    beats(1, 0, 0);
    cycle(0, 0, '0, 0, 1, AW'(63));
    cycle(0, 0, '0, 0, 1, AW'(64));
    idle(1);
    fetches(15);

    // 64 beats without load_last overflow, then load_start clears the error
    fill_random(DEPTH);
    start(0, '0);
    beats(0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, DW'($urandom), 1, 1, pick_addr());
    fill_random(5);
    start(0, '0);
    beats(1, 0, 0);
    fetches(8);

    // Preempt RUN with a fetch in the same cycle, reload 3 words, check word 3 kept
    start(1, AW'(3));
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back(DW'(32'hA0 + i));
    beats(1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 0, 1, AW'(i));
    idle(1);

    // Asynchronous reset after 4 of 8 beats
    fill_random(8);
    start(0, '0);
    for (int i = 0; i < 4; i++) cycle(0, 1, wq[i], 0, 0, '0);
    bus.load_valid = 1'b1; bus.load_data = wq[4];
    #2 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    m_mode = MI; m_count = 0; m_err = 1'b0;
    sb.delete();
    bus.load_valid = 1'b0;
    #3 reset = 1'b1;
    idle(2);
    fill_random(8);
    start(0, '0);
    beats(1, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, '0, 0, 1, AW'(i));
    fetches(20);
    idle(3);

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
